dct_quant_zigzag: RTL
=====================

Name: dct_quant_zigzag

Overview:
- Downstream consumer of the 8x8 2-D DCT stage.
- Captures one 64-coefficient block (9-bit signed, raster order) in a single handshake.
- Quantises each coefficient by a reciprocal-multiply against a constant quant table.
- Streams the results out one per cycle in JPEG zigzag order over a valid/ready interface, feeding the entropy-coder stage.

Parameters:
- IN_W, 9: input coefficient width, signed.
- OUT_W, 9: output coefficient width, signed.
- RECIP_W, 17: reciprocal width, unsigned. Value is round(65536/Q), Q in 1..255, so Q=1 gives 65536.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  coef_in holds a complete block.
- in_ready  out  1  block accepted on in_valid&&in_ready.
- coef_in  in  9x64 (unpacked [63:0])  signed coefficients, index = row*8+col.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  9  signed quantised coefficient.
- out_index  out  6  zigzag position 0..63.
- out_last  out  1  final coefficient of block.
- block_done  out  1  one-cycle pulse after the last transfer.

Behaviour:
- Reset (async):
  - state=IDLE.
  - in_ready, out_valid, out_last and block_done are 0; out_data and out_index are 0.
  - in_ready held 0 while reset is high.
  - Reset mid-QUANT or mid-STREAM discards the block, with no partial output after release.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register all 64 coef_in into raw_buf, clear k and last_nz, go to QUANT.
- QUANT: 64 cycles, k=0..63, one multiplier.
  - Pick c=raw_buf[ZZ[k]] and m=|c| (up to 256).
  - q=(m*RECIP[ZZ[k]] + 2^15)>>16, rounding half away from zero.
  - Store q_buf[k] = sign(c) ? -q : q.
  - m=256 occurs only for c=-256; the result fits in 9 bits, so no saturation.
  - If the result is nonzero, last_nz<=k.
  - After k=63, go to STREAM with idx=0.
- STREAM:
  - out_valid=1, out_data=q_buf[idx], out_index=idx.
  - out_data, out_index and out_last hold stable while out_valid&&!out_ready.
  - idx increments on each out_valid&&out_ready.
  - out_last=1 when idx==63 (EOB variant below).
  - On the last transfer, go to DONE.
- DONE: one cycle.
  - block_done=1, then return to IDLE.
  - in_ready is 0 during QUANT, STREAM and DONE, so there is no overlap.
- Latency:
  - Capture edge is T0.
  - QUANT occupies T1..T64.
  - out_valid first seen high after edge T65.
  - With out_ready tied 1, the block drains in 64 cycles.
  - block_done rises after edge T129; in_ready is back at T130.
- Throughput: one block per 130 cycles minimum.

Optional Feature:
- DCT_ZZ_EOB_EN defined: the stream is truncated after the last nonzero zigzag coefficient.
  - out_last asserts at idx==last_nz.
  - An all-zero block emits only idx 0 (value 0) with out_last=1.
  - Trailing zeros are never presented.
- Undefined: all 64 coefficients are always emitted, out_last only at idx 63, and last_nz logic is absent.

Decomposition:
- Package dct_pkg holds:
  - typedef coef_t (signed [8:0]) and qcoef_t;
  - localparam ZZ[0:63]: zigzag-to-raster map;
  - QTAB[0:63]: standard JPEG luminance table, raster order;
  - RECIP[0:63]: round(65536/QTAB), precomputed constants;
  - state enum {IDLE, QUANT, STREAM, DONE}.
- One sub-module, dct_quant_mul: combinational sign/magnitude, multiply, round and re-sign for one coefficient.
- FSM, buffers and handshake stay in the top.

Test Plan:
- Single DC: coef_in[0]=200, rest 0, out_ready=1.
  - Required: index0 = 13 (200/16 rounded), indices 1..63 = 0.
  - out_valid first high at T65; out_last at index 63; block_done pulse at T129.
- Sign symmetry: coef_in[0]=-200, coef_in[1]=100 (Q=11), coef_in[8]=-100 (Q=12).
  - Required outputs: idx0=-13, idx1=9, idx2=-8.
- Zigzag order: coef_in[r]=r clamped so each quantises nonzero; bench uses a table with all Q=1.
  - Required: out_data sequence equals ZZ[] (0,1,8,16,9,2,3,10,...).
- Backpressure: toggle out_ready 1010... and hold 0 for 5 cycles mid-block.
  - Required: no lost or duplicated index; data stable while stalled; in_ready=0 for new in_valid during STREAM.
- Reset mid-stream: assert reset at idx 20.
  - Required: outputs 0 immediately; after release in_ready=1; the next block streams from idx 0 correctly.
- EOB (DCT_ZZ_EOB_EN): nonzero only at raster 9 (zigzag 4).
  - Required: five transfers, idx 4 with out_last=1.
  - All-zero block gives a single transfer with out_last=1.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types, zigzag map, JPEG luminance quant table and its reciprocals
// for the DCT quantise/zigzag slice.
package dct_pkg;

  localparam int IN_W    = 9;
  localparam int OUT_W   = 9;
  localparam int RECIP_W = 17;

  typedef logic signed [IN_W-1:0]  coef_t;
  typedef logic signed [OUT_W-1:0] qcoef_t;
  typedef logic [RECIP_W-1:0]      recip_t;

  typedef enum logic [1:0] {IDLE, QUANT, STREAM, DONE} state_t;

  // Zigzag position -> raster index (row*8+col).
  localparam logic [5:0] ZZ [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam logic [7:0] QTAB [0:63] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  // round(65536/QTAB), raster order.
  localparam recip_t RECIP [0:63] = '{
    17'd4096, 17'd5958, 17'd6554, 17'd4096, 17'd2731, 17'd1638, 17'd1285, 17'd1074,
    17'd5461, 17'd5461, 17'd4681, 17'd3449, 17'd2521, 17'd1130, 17'd1092, 17'd1192,
    17'd4681, 17'd5041, 17'd4096, 17'd2731, 17'd1638, 17'd1150, 17'd950,  17'd1170,
    17'd4681, 17'd3855, 17'd2979, 17'd2260, 17'd1285, 17'd753,  17'd819,  17'd1057,
    17'd3641, 17'd2979, 17'd1771, 17'd1170, 17'd964,  17'd601,  17'd636,  17'd851,
    17'd2731, 17'd1872, 17'd1192, 17'd1024, 17'd809,  17'd630,  17'd580,  17'd712,
    17'd1337, 17'd1024, 17'd840,  17'd753,  17'd636,  17'd542,  17'd546,  17'd649,
    17'd910,  17'd712,  17'd690,  17'd669,  17'd585,  17'd655,  17'd636,  17'd662
  };

endpackage

// File: rtl/dct_quant_zigzag_if.sv
// Block-in / coefficient-stream-out bundle; slave is the quantiser side,
// master is the side that supplies blocks and sinks the stream.
interface dct_quant_zigzag_if;
  import dct_pkg::*;

  logic       in_valid;
  logic       in_ready;
  coef_t      coef_in [63:0];
  logic       out_valid;
  logic       out_ready;
  qcoef_t     out_data;
  logic [5:0] out_index;
  logic       out_last;
  logic       block_done;

  modport slave (
    input  in_valid, coef_in, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, block_done
  );

  modport master (
    output in_valid, coef_in, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, block_done
  );

endinterface

// File: rtl/dct_quant_mul.sv
// One-coefficient quantiser: |c| * round(2^16/Q), add half, drop 16 bits, re-sign.
// Purely combinational; rounding is half away from zero by symmetry.
module dct_quant_mul
  import dct_pkg::*;
(
  input  coef_t  coef,
  input  recip_t recip,
  output qcoef_t q
);

  localparam int P_W = IN_W + RECIP_W;

  logic                     neg;
  logic [IN_W-1:0]          mag;
  logic [P_W-1:0]           sum;
  logic [P_W-17-OUT_W:0]    ovf_unused;
  logic [OUT_W-1:0]         qmag;
  logic [15:0]              frac_unused;

  assign neg = coef[IN_W-1];
  // -(-256) wraps to 9'h100, which reads back correctly as magnitude 256.
  assign mag = neg ? unsigned'(-coef) : unsigned'(coef);
  assign sum = P_W'(mag) * P_W'(recip) + P_W'(32768);
  assign {ovf_unused, qmag, frac_unused} = sum;
  assign q = neg ? qcoef_t'(-qmag) : qcoef_t'(qmag);

endmodule

// File: rtl/dct_quant_zigzag.sv
// Captures a 64-coef block, quantises it over 64 cycles, then streams it in zigzag order
// (first out_valid 65 edges after capture, stalls on out_ready). DCT_ZZ_EOB_EN truncates after last nonzero.
module dct_quant_zigzag
  import dct_pkg::*;
(
  input logic              clock,
  input logic              reset,
  dct_quant_zigzag_if.slave bus
);

  state_t     state, next_state;
  coef_t      raw_buf [63:0];
  qcoef_t     q_buf   [63:0];
  logic [5:0] k;
  logic [5:0] load_idx;
  logic [5:0] last_idx;
  logic       capture;
  logic       xfer;
  qcoef_t     mul_out;

  assign capture = (state == IDLE) && bus.in_valid && bus.in_ready;
  assign xfer    = bus.out_valid && bus.out_ready;
  // First load presents the current index; later loads advance to the next one.
  assign load_idx = bus.out_valid ? bus.out_index + 6'd1 : bus.out_index;

`ifdef DCT_ZZ_EOB_EN
  logic [5:0] last_nz;
  assign last_idx = last_nz;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_nz <= '0;
    end else if (capture) begin
      last_nz <= '0;
    end else if (state == QUANT && mul_out != '0) begin
      last_nz <= k;
    end
  end
`else
  assign last_idx = 6'd63;
`endif

  dct_quant_mul u_mul (
    .coef  (raw_buf[ZZ[k]]),
    .recip (RECIP[ZZ[k]]),
    .q     (mul_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state     = state;
    bus.block_done = 1'b0;
    case (state)
      IDLE:    if (capture) next_state = QUANT;
      QUANT:   if (k == 6'd63) next_state = STREAM;
      STREAM:  if (xfer && bus.out_last) next_state = DONE;
      DONE: begin
        bus.block_done = 1'b1;
        next_state     = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Block storage carries no reset: contents are always rewritten before use.
  always_ff @(posedge clock) begin
    if (capture) raw_buf <= bus.coef_in;
    if (state == QUANT) q_buf[k] <= mul_out;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
      k             <= '0;
    end else begin
      bus.in_ready <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (capture) begin
            k             <= '0;
            bus.out_index <= '0;
          end
        end
        QUANT: k <= k + 6'd1;
        STREAM: begin
          if (!bus.out_valid || bus.out_ready) begin
            if (bus.out_valid && bus.out_last) begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
            end else begin
              bus.out_valid <= 1'b1;
              bus.out_index <= load_idx;
              bus.out_data  <= q_buf[load_idx];
              bus.out_last  <= (load_idx == last_idx);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
